// File: rtl/video_timing_gen_if.sv
// Raster output bundle of video_timing_gen: blanking, sync, pixel coordinates, start-of-frame
// and RGB, all registered and mutually aligned.
interface video_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic [1:0]    vh_blank;  // {Vblank, Hblank}
  logic [2:0]    dvh_sync;  // {D_sync, Vsync, Hsync}
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          sof;
  logic [23:0]   vid_rgb;

  modport master (output vh_blank, dvh_sync, pix_x, pix_y, sof, vid_rgb);
  modport slave  (input  vh_blank, dvh_sync, pix_x, pix_y, sof, vid_rgb);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: hc/vc counters advanced on cen_i, decoded and registered into
// blanking/sync/coordinates/sof. Define VTG_PATTERN_EN to add an 8-bar colour pattern on vid_rgb.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter int unsigned HS_POL   = 1,
  parameter int unsigned VS_POL   = 1,
  parameter int unsigned CW       = 12
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cen_i,
  video_timing_gen_if.master vid_o
);
  localparam int unsigned HTotal   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd = HSyncBeg + H_SYNC;
  localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd = VSyncBeg + V_SYNC;
  localparam logic        HsOn     = (HS_POL != 0);
  localparam logic        VsOn     = (VS_POL != 0);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CW == 0) begin : gen_bad_param
    $error("video_timing_gen: every timing parameter must be >= 1");
  end
  if (CW < 32) begin : gen_cw_chk
    if (HTotal >= (32'd1 << CW) || VTotal >= (32'd1 << CW)) begin : gen_bad_cw
      $error("video_timing_gen: H/V totals do not fit in CW bits");
    end
  end

  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic          h_last, v_last, hblank, vblank, de, hsync, vsync;
  logic [1:0]    vh_blank_q, vh_blank_d;
  logic [2:0]    dvh_sync_q, dvh_sync_d;
  logic [CW-1:0] pix_x_q, pix_y_q;
  logic          sof_q, sof_d;

  always_comb begin
    h_last     = (hc_q == CW'(HTotal - 1));
    v_last     = (vc_q == CW'(VTotal - 1));
    hc_d       = h_last ? '0 : hc_q + CW'(1);
    vc_d       = vc_q;
    if (h_last) begin
      vc_d = v_last ? '0 : vc_q + CW'(1);
    end
    hblank     = (hc_q >= CW'(H_ACTIVE));
    vblank     = (vc_q >= CW'(V_ACTIVE));
    de         = !hblank && !vblank;
    hsync      = (hc_q >= CW'(HSyncBeg) && hc_q < CW'(HSyncEnd)) ? HsOn : !HsOn;
    // Vsync spans whole lines, blanking included
    vsync      = (vc_q >= CW'(VSyncBeg) && vc_q < CW'(VSyncEnd)) ? VsOn : !VsOn;
    vh_blank_d = {vblank, hblank};
    dvh_sync_d = {de, vsync, hsync};
    sof_d      = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hc_q       <= '0;
      vc_q       <= '0;
      vh_blank_q <= 2'b11;
      dvh_sync_q <= {1'b0, !VsOn, !HsOn};
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      sof_q      <= 1'b0;
    end else if (cen_i) begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      vh_blank_q <= vh_blank_d;
      dvh_sync_q <= dvh_sync_d;
      pix_x_q    <= hc_q;
      pix_y_q    <= vc_q;
      sof_q      <= sof_d;
    end
  end

  assign vid_o.vh_blank = vh_blank_q;
  assign vid_o.dvh_sync = dvh_sync_q;
  assign vid_o.pix_x    = pix_x_q;
  assign vid_o.pix_y    = pix_y_q;
  assign vid_o.sof      = sof_q;

`ifdef VTG_PATTERN_EN
  // Narrow rasters (H_ACTIVE < 8) fall back to one pixel per bar
  localparam int unsigned BarW = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [CW-1:0] bar_div;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb, rgb_d, rgb_q;

  always_comb begin
    bar_div = hc_q / CW'(BarW);
    bar_idx = (bar_div > CW'(7)) ? 3'd7 : bar_div[2:0];
    unique case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    rgb_d = de ? bar_rgb : 24'h000000;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_q <= '0;
    end else if (cen_i) begin
      rgb_q <= rgb_d;
    end
  end

  assign vid_o.vid_rgb = rgb_q;
`else
  assign vid_o.vid_rgb = 24'h000000;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 14x7 raster, run with both sync polarities at once;
// stimulus pushes hand-modelled beats, a monitor pops and compares on every enabled beat.
module tb_video_timing_gen;
  localparam int unsigned HT    = 14;
  localparam int unsigned VT    = 7;
  localparam int          FRAME = 98;

  typedef logic [53:0] vec_t;  // {vh_blank, dvh_sync, pix_x, pix_y, sof, rgb}

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cen   = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(12)) vif_p ();
  video_timing_gen_if #(.CW(12)) vif_n ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(12)
  ) dut_p (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .cen_i  (cen),
    .vid_o  (vif_p)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CW(12)
  ) dut_n (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .cen_i  (cen),
    .vid_o  (vif_n)
  );

  vec_t act_p, act_n;
  assign act_p = {vif_p.vh_blank, vif_p.dvh_sync, vif_p.pix_x, vif_p.pix_y, vif_p.sof,
                  vif_p.vid_rgb};
  assign act_n = {vif_n.vh_blank, vif_n.dvh_sync, vif_n.pix_x, vif_n.pix_y, vif_n.sof,
                  vif_n.vid_rgb};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected outputs for raster position (hc, vc) on the 14x7 test raster
  function automatic vec_t model(input int hc, input int vc, input logic pol);
    logic        hb, vb, ds, hs, vs, sof;
    logic [23:0] rgb;
    hb  = (hc >= 8);
    vb  = (vc >= 4);
    ds  = !hb && !vb;
    hs  = (hc == 10 || hc == 11) ? pol : !pol;
    vs  = (vc == 5) ? pol : !pol;
    sof = (hc == 0 && vc == 0);
    rgb = 24'h000000;
`ifdef VTG_PATTERN_EN
    if (ds) begin
      case (hc)
        0:       rgb = 24'hFFFFFF;
        1:       rgb = 24'hFFFF00;
        2:       rgb = 24'h00FFFF;
        3:       rgb = 24'h00FF00;
        4:       rgb = 24'hFF00FF;
        5:       rgb = 24'hFF0000;
        6:       rgb = 24'h0000FF;
        default: rgb = 24'h000000;
      endcase
    end
`endif
    return {vb, hb, ds, vs, hs, 12'(hc), 12'(vc), sof, rgb};
  endfunction

  function automatic vec_t rst_vec(input logic pol);
    return {2'b11, 1'b0, !pol, !pol, 12'd0, 12'd0, 1'b0, 24'h000000};
  endfunction

  vec_t q_p[$];
  vec_t q_n[$];
  int   mh = 0;
  int   mv = 0;

  task automatic beat(input logic en);
    @(negedge clk);
    cen = en;
    if (en) begin
      q_p.push_back(model(mh, mv, 1'b1));
      q_n.push_back(model(mh, mv, 1'b0));
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  // Monitor
  vec_t last_p, last_n, exp_p, exp_n;
  logic en_s;
  int   bc       = 0;
  int   ds_cnt   = 0;
  int   prev_sof = -1;

  always begin
    @(posedge clk);
    en_s = cen && rst_n;
    #1;
    if (!rst_n) begin
      chk("reset_hold_p", act_p, rst_vec(1'b1));
      chk("reset_hold_n", act_n, rst_vec(1'b0));
      last_p   = rst_vec(1'b1);
      last_n   = rst_vec(1'b0);
      bc       = 0;
      ds_cnt   = 0;
      prev_sof = -1;
    end else if (en_s) begin
      if (q_p.size() == 0 || q_n.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue want entry at beat %0d", bc);
      end else begin
        exp_p = q_p.pop_front();
        exp_n = q_n.pop_front();
        chk($sformatf("beat%0d_pol1", bc), act_p, exp_p);
        chk($sformatf("beat%0d_pol0", bc), act_n, exp_n);
        last_p = exp_p;
        last_n = exp_n;
      end
      if (vif_p.sof) begin
        if (prev_sof >= 0) chk("sof_period", 54'(bc - prev_sof), 54'(FRAME));
        prev_sof = bc;
      end
      if (bc < FRAME && vif_p.dvh_sync[2]) ds_cnt++;
      bc++;
      if (bc == FRAME) chk("dsync_per_frame", 54'(ds_cnt), 54'd32);
    end else begin
      chk($sformatf("hold_pol1_after%0d", bc), act_p, last_p);
      chk($sformatf("hold_pol0_after%0d", bc), act_n, last_n);
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pol1", act_p, rst_vec(1'b1));
    chk("reset_pol0", act_n, rst_vec(1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Free-running: two frames and a bit
    repeat (2 * FRAME + 6) beat(1'b1);

    // 50% duty clock enable
    repeat (2 * FRAME + 10) begin
      beat(1'b1);
      beat(1'b0);
    end

    // Advance until pixel (5,2) is the one being output, then reset between edges
    for (int i = 0; i < FRAME && !(mh == 6 && mv == 2); i++) beat(1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    cen   = 1'b0;
    mh    = 0;
    mv    = 0;
    #1;
    chk("async_reset_pol1", act_p, rst_vec(1'b1));
    chk("async_reset_pol0", act_n, rst_vec(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) beat(1'b1);
    beat(1'b0);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 54'(q_p.size() + q_n.size()), 54'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
